count_event_tracker: RTL and testbench
======================================

# count_event_tracker

Downstream monitor for the up/down counter: samples the counter's `count_out` and control inputs every clock, detects wrap-around and threshold-hit events, and maintains a signed wrap tally. It produces registered `max_count`/`zero` status flags. Detected events are queued in a 4-entry FIFO and presented to a consumer over a valid/ready handshake.

## Interface
- `WIDTH`, 4: counter width; must match the counter's `width`.
- `WRAP_WIDTH`, 8: width of the wrap tally.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `count_in`  input  WIDTH  counter `count_out`.
- `load_n`  input  1  counter's active-low synchronous load, same timing as the counter sees it.
- `threshold`  input  WIDTH  compare value; quasi-static.
- `max_count`  output  1  registered; `count_in` was all ones last cycle.
- `zero`  output  1  registered; `count_in` was 0 last cycle.
- `wrap_cnt`  output  WRAP_WIDTH  +1 per up-wrap, −1 per down-wrap, modulo 2^WRAP_WIDTH.
- `evt_valid`  output  1  FIFO not empty.
- `evt_code`  output  2  head event type: 00 up-wrap, 01 down-wrap, 10 threshold hit, 11 reserved (never produced).
- `evt_count`  output  WIDTH  `count_in` value at detection, for the head event.
- `evt_ready`  input  1  consumer accepts the head event.
- `drop_err`  output  1  sticky; an event was lost because the FIFO was full.

## Operation
- Sample registers, updated every edge: `prev` ← `count_in`, `load_q` ← `load_n`, `prev_valid` ← 1.
- Detection is armed only when `prev_valid`=1 and `load_q`=1. A transition following a load is never treated as a wrap or a hit.
- When armed, the following detections apply:
  - Up-wrap: `prev`=all ones and `count_in`=0.
  - Down-wrap: `prev`=0 and `count_in`=all ones.
  - Threshold hit: `count_in`=`threshold` and `prev`≠`threshold`.
- At most one event is pushed per cycle, with priority wrap > threshold hit. A hit coinciding with a wrap (e.g. `threshold`=0 on an up-wrap) is not queued and does not set `drop_err`.
- `wrap_cnt` updates on every detected wrap, regardless of FIFO state. It wraps silently.
- FIFO depth is 4.
  - Pop occurs when `evt_valid`&&`evt_ready`.
  - Push is accepted when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the push is discarded and `drop_err` is set; `drop_err` clears only on reset.
- `evt_code`/`evt_count` must be held stable while `evt_valid`=1 and `evt_ready`=0.
- `evt_code`/`evt_count` are don't-care while `evt_valid`=0.
- `max_count` ← (`count_in`=all ones); `zero` ← (`count_in`=0). Both update every edge, independent of arming.

## Timing
- Reset (`rst`=0, asynchronous) clears the following to 0: `prev`, `load_q`, `prev_valid`, `wrap_cnt`, the FIFO pointers and count, `evt_valid`, `max_count`, `zero`, and `drop_err`.
- Reset asserted mid-operation flushes all queued events immediately.
- After reset release, the first sampling edge only loads `prev`; the earliest possible detection is on the second edge.
- Event latency: if `count_in` shows the transition in cycle t, the push occurs at the end of t and `evt_valid` is high in cycle t+1 (empty FIFO).
- `wrap_cnt` reflects a wrap in cycle t+1. `max_count`/`zero` lag `count_in` by one cycle.
- No combinational path exists from `evt_ready` to `evt_valid`, or from any input to any output.

## Test plan
- **Up-wrap:** `load_n`=1, `threshold`=5, `count_in` 13,14,15,0 on consecutive cycles → one event with code 00, `evt_count`=0, valid on the cycle after the 0. `wrap_cnt` 0→1. `max_count` high one cycle after the 15.
- **Down-wrap:** `count_in` 1,0,15 with `threshold`=8 → one event with code 01, `evt_count`=15. `wrap_cnt` decrements, so 0→255 from reset.
- **Load suppression:** `count_in`=15, `load_n`=0 for one cycle, then `count_in`=0 → no event and `wrap_cnt` unchanged. With `load_n` back to 1 and `threshold`=1, `count_in` 0,1 → event with code 10, `evt_count`=1.
- **Priority:** `threshold`=0, `count_in` 15→0 → only the code 00 event is queued; `drop_err` stays 0.
- **Backpressure and full:** `evt_ready`=0 while 5 wraps occur → `evt_valid`=1, the first 4 events are held in order, the 5th is dropped, and `drop_err`=1. Raising `evt_ready` drains exactly 4 events, each on one cycle. A push coinciding with a pop on a full FIFO is accepted.
- **Reset mid-stream:** 3 events queued, `rst` pulsed low between edges → `evt_valid`, `wrap_cnt`, and `drop_err` read 0 immediately. The first post-reset edge produces no event, even if `count_in`=0 follows 15.

Source files
------------

// File: rtl/count_event_tracker.sv
// Monitors an up/down counter's output: detects wrap-around and threshold
// hits, keeps a signed wrap tally and queues events in a 4-deep FIFO.
module count_event_tracker #(
  parameter int WIDTH      = 4,
  parameter int WRAP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  load_n,
  input  logic [WIDTH-1:0]      threshold,
  output logic                  max_count,
  output logic                  zero,
  output logic [WRAP_WIDTH-1:0] wrap_cnt,
  output logic                  evt_valid,
  output logic [1:0]            evt_code,
  output logic [WIDTH-1:0]      evt_count,
  input  logic                  evt_ready,
  output logic                  drop_err
);

  localparam int DEPTH = 4;
  localparam logic [WRAP_WIDTH-1:0] WRAP_ONE = 1;
  localparam logic [2:0] FILL_FULL = 3'(DEPTH);

  logic [WIDTH-1:0] prev;
  logic             load_q;
  logic             prev_valid;

  logic       armed, up_wrap, down_wrap, hit;
  logic       push, pop, full, push_ok;
  logic [1:0] push_code;

  logic [1:0]       wr_ptr, rd_ptr;
  logic [2:0]       fill;
  logic [1:0]       mem_code  [DEPTH];
  logic [WIDTH-1:0] mem_count [DEPTH];

  always_comb begin
    armed     = prev_valid && load_q;
    up_wrap   = armed && (prev == '1) && (count_in == '0);
    down_wrap = armed && (prev == '0) && (count_in == '1);
    hit       = armed && (count_in == threshold) && (prev != threshold);
    push      = up_wrap || down_wrap || hit;
    // Wraps take priority; a coincident hit is simply not reported.
    if (up_wrap)        push_code = 2'b00;
    else if (down_wrap) push_code = 2'b01;
    else                push_code = 2'b10;
  end

  assign evt_valid = (fill != '0);
  assign full      = (fill == FILL_FULL);
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = push && (!full || pop);
  assign evt_code  = mem_code[rd_ptr];
  assign evt_count = mem_count[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev       <= '0;
      load_q     <= 1'b0;
      prev_valid <= 1'b0;
      max_count  <= 1'b0;
      zero       <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      prev       <= count_in;
      load_q     <= load_n;
      prev_valid <= 1'b1;
      max_count  <= (count_in == '1);
      zero       <= (count_in == '0);
      if (up_wrap)
        wrap_cnt <= wrap_cnt + WRAP_ONE;
      else if (down_wrap)
        wrap_cnt <= wrap_cnt - WRAP_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   fill <= fill + 3'd1;
        2'b01:   fill <= fill - 3'd1;
        default: fill <= fill;
      endcase
      if (push && !push_ok) drop_err <= 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed while evt_valid=1.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_code[wr_ptr]  <= push_code;
      mem_count[wr_ptr] <= count_in;
    end
  end

endmodule

// File: tb/tb_count_event_tracker.sv
// Bench for count_event_tracker: table of per-cycle vectors plus
// hand-written backpressure/reset sequences, checked against a queue model.
module tb_count_event_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in;
  logic       load_n;
  logic [3:0] threshold;
  logic       max_count, zero;
  logic [7:0] wrap_cnt;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [3:0] evt_count;
  logic       evt_ready;
  logic       drop_err;

  count_event_tracker #(.WIDTH(4), .WRAP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .load_n(load_n),
    .threshold(threshold), .max_count(max_count), .zero(zero),
    .wrap_cnt(wrap_cnt), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_count(evt_count), .evt_ready(evt_ready), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] cnt;
  } evt_t;

  typedef struct {
    logic [3:0] c;
    logic       ld;
    logic [3:0] thr;
    logic       rdy;
    logic       e_max;
    logic       e_zero;
    logic [7:0] e_wrap;
    logic       e_valid;
    logic       e_drop;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  evt_t       sb[$];
  logic [3:0] m_prev;
  logic       m_load_q, m_pv, m_drop, m_max, m_zero;
  logic [7:0] m_wrap;

  vec_t tbl[17];

  function automatic vec_t mk(input logic [3:0] c, input logic ld, input logic [3:0] thr,
                              input logic rdy, input logic e_max, input logic e_zero,
                              input logic [7:0] e_wrap, input logic e_valid, input logic e_drop);
    vec_t v;
    v.c = c; v.ld = ld; v.thr = thr; v.rdy = rdy; v.e_max = e_max; v.e_zero = e_zero;
    v.e_wrap = e_wrap; v.e_valid = e_valid; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_prev = '0; m_load_q = 1'b0; m_pv = 1'b0; m_drop = 1'b0;
    m_max = 1'b0; m_zero = 1'b0; m_wrap = '0;
  endtask

  // One clock: drive inputs, check the head against the scoreboard if it is
  // popped this edge, advance the model, then check registered outputs.
  task automatic cycle(input logic [3:0] c, input logic ld, input logic [3:0] thr,
                       input logic rdy);
    logic armed, up, dn, hit;
    evt_t e;
    count_in = c; load_n = ld; threshold = thr; evt_ready = rdy;
    #1;
    check("evt_valid_pre", {31'd0, evt_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0 && rdy) begin
      e = sb.pop_front();
      check("evt_code", {30'd0, evt_code}, {30'd0, e.code});
      check("evt_count", {28'd0, evt_count}, {28'd0, e.cnt});
    end
    armed = m_pv && m_load_q;
    up  = armed && m_prev == 4'hF && c == 4'h0;
    dn  = armed && m_prev == 4'h0 && c == 4'hF;
    hit = armed && c == thr && m_prev != thr;
    if (up || dn || hit) begin
      e.code = up ? 2'b00 : (dn ? 2'b01 : 2'b10);
      e.cnt  = c;
      if (sb.size() < 4) sb.push_back(e);
      else m_drop = 1'b1;
    end
    if (up) m_wrap = m_wrap + 8'd1;
    if (dn) m_wrap = m_wrap - 8'd1;
    m_prev = c; m_load_q = ld; m_pv = 1'b1;
    m_max = (c == 4'hF); m_zero = (c == 4'h0);
    @(posedge clk);
    #1;
    check("max_count", {31'd0, max_count}, {31'd0, m_max});
    check("zero", {31'd0, zero}, {31'd0, m_zero});
    check("wrap_cnt", {24'd0, wrap_cnt}, {24'd0, m_wrap});
    check("drop_err", {31'd0, drop_err}, {31'd0, m_drop});
    check("evt_valid", {31'd0, evt_valid}, {31'd0, sb.size() != 0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            c     ld    thr   rdy   max   zero  wrap   valid drop
    tbl[0]  = mk(4'd13, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    tbl[1]  = mk(4'd14, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    tbl[2]  = mk(4'd15, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
    tbl[3]  = mk(4'd0,  1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 8'd1,   1'b1, 1'b0);
    tbl[4]  = mk(4'd0,  1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 8'd1,   1'b0, 1'b0);
    tbl[5]  = mk(4'd1,  1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 8'd1,   1'b0, 1'b0);
    tbl[6]  = mk(4'd0,  1'b1, 4'd8, 1'b1, 1'b0, 1'b1, 8'd1,   1'b0, 1'b0);
    tbl[7]  = mk(4'd15, 1'b1, 4'd8, 1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0);
    tbl[8]  = mk(4'd15, 1'b1, 4'd8, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
    tbl[9]  = mk(4'd15, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
    tbl[10] = mk(4'd0,  1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 8'd0,   1'b0, 1'b0);
    tbl[11] = mk(4'd0,  1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 8'd0,   1'b0, 1'b0);
    tbl[12] = mk(4'd1,  1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0);
    tbl[13] = mk(4'd1,  1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    tbl[14] = mk(4'd15, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
    tbl[15] = mk(4'd0,  1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 8'd1,   1'b1, 1'b0);
    tbl[16] = mk(4'd0,  1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 8'd1,   1'b0, 1'b0);

    rst = 1'b0; count_in = 4'd0; load_n = 1'b1; threshold = 4'd5; evt_ready = 1'b1;
    model_reset();
    #2;
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_wrap_cnt", {24'd0, wrap_cnt}, 32'd0);
    check("rst_drop_err", {31'd0, drop_err}, 32'd0);
    check("rst_max_count", {31'd0, max_count}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    // Model stayed in reset; the edge just taken was its first sampling edge.
    m_prev = count_in; m_load_q = load_n; m_pv = 1'b1; m_zero = 1'b1;
    check("first_edge_zero", {31'd0, zero}, 32'd1);

    // Restart from a clean reset so the table starts with prev_valid=0.
    rst = 1'b0; #1; rst = 1'b1;
    model_reset();

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].c, tbl[i].ld, tbl[i].thr, tbl[i].rdy);
      check($sformatf("tbl%0d_max", i), {31'd0, max_count}, {31'd0, tbl[i].e_max});
      check($sformatf("tbl%0d_zero", i), {31'd0, zero}, {31'd0, tbl[i].e_zero});
      check($sformatf("tbl%0d_wrap", i), {24'd0, wrap_cnt}, {24'd0, tbl[i].e_wrap});
      check($sformatf("tbl%0d_valid", i), {31'd0, evt_valid}, {31'd0, tbl[i].e_valid});
      check($sformatf("tbl%0d_drop", i), {31'd0, drop_err}, {31'd0, tbl[i].e_drop});
    end

    // Backpressure: five wraps with ready low; the fifth is dropped.
    cycle(4'd15, 1'b1, 4'd5, 1'b0);
    cycle(4'd0,  1'b1, 4'd5, 1'b0);
    cycle(4'd15, 1'b1, 4'd5, 1'b0);
    cycle(4'd0,  1'b1, 4'd5, 1'b0);
    check("full_no_drop_yet", {31'd0, drop_err}, 32'd0);
    check("full_head_code", {30'd0, evt_code}, 32'd1);
    check("full_head_count", {28'd0, evt_count}, 32'd15);
    cycle(4'd15, 1'b1, 4'd5, 1'b0);
    check("fifth_dropped", {31'd0, drop_err}, 32'd1);
    check("held_code", {30'd0, evt_code}, 32'd1);
    check("queued_count", sb.size(), 32'd4);
    for (int i = 0; i < 4; i++) cycle(4'd15, 1'b1, 4'd5, 1'b1);
    check("drained", {31'd0, evt_valid}, 32'd0);

    // Full FIFO with a simultaneous pop and push: push must be accepted.
    cycle(4'd0,  1'b1, 4'd5, 1'b0);
    cycle(4'd15, 1'b1, 4'd5, 1'b0);
    cycle(4'd0,  1'b1, 4'd5, 1'b0);
    cycle(4'd15, 1'b1, 4'd5, 1'b0);
    cycle(4'd0,  1'b1, 4'd5, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'd0, 1'b1, 4'd5, 1'b1);
    check("full_swap_drained", {31'd0, evt_valid}, 32'd0);

    // Reset mid-stream with three events queued.
    cycle(4'd15, 1'b1, 4'd5, 1'b0);
    cycle(4'd0,  1'b1, 4'd5, 1'b0);
    cycle(4'd15, 1'b1, 4'd5, 1'b0);
    check("pre_reset_queued", sb.size(), 32'd3);
    rst = 1'b0;
    #1;
    check("midrst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("midrst_wrap_cnt", {24'd0, wrap_cnt}, 32'd0);
    check("midrst_drop_err", {31'd0, drop_err}, 32'd0);
    #1;
    rst = 1'b1;
    model_reset();
    cycle(4'd0,  1'b1, 4'd5, 1'b1);
    check("post_rst_no_event", {31'd0, evt_valid}, 32'd0);
    cycle(4'd15, 1'b1, 4'd5, 1'b1);
    check("down_from_reset", {24'd0, wrap_cnt}, 32'd255);
    cycle(4'd15, 1'b1, 4'd5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
